prog_encoder: RTL and testbench

Program encoder/loader: accepts instruction fields (type, opcode, immediate) over a valid/ready stream, packs them into the 9-bit instruction format consumed by the control decoder, and writes them sequentially into instruction ROM. It sits between the test/boot loader and the instruction memory write port, ahead of fetch and decode. It rejects illegal run-type opcodes and stops at memory capacity.

---
 rtl/isa_pkg.sv | 52 +++++
 rtl/instr_pack.sv | 19 +
 rtl/prog_encoder.sv | 177 +++++++++++++++++
 tb/tb_prog_encoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction-type bits, the 9-bit encoder
// and the program-encoder FSM state type.
package isa_pkg;

  typedef enum logic [4:0] {
    OpLdi  = 5'h00,
    OpLd   = 5'h01,
    OpSt   = 5'h02,
    OpAdd  = 5'h03,
    OpSub  = 5'h04,
    OpXor  = 5'h05,
    OpOr   = 5'h06,
    OpAnd  = 5'h07,
    OpJmp  = 5'h08,
    OpBeq  = 5'h09,
    OpBlt  = 5'h0A,
    OpBgt  = 5'h0B,
    OpLsl  = 5'h0C,
    OpLsr  = 5'h0D,
    OpSubu = 5'h0E,
    OpSlt  = 5'h0F,
    OpSgt  = 5'h10,
    OpAddu = 5'h11
  } opcode_e;

  // Highest legal run-type opcode; everything above is reserved.
  localparam logic [4:0] OPC_MAX = 5'h11;

  localparam logic ITYPE_RUN = 1'b0;
  localparam logic ITYPE_PUT = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StErr
  } enc_state_e;

  // Bit 0 is the type bit; run-type words keep [8:6] reserved as zero.
  function automatic logic [8:0] encode_instr(input logic       put,
                                              input logic [4:0] opcode,
                                              input logic [7:0] imm);
    logic [8:0] word;
    if (put == ITYPE_PUT) begin
      word = {imm, ITYPE_PUT};
    end else begin
      word = {3'b000, opcode, ITYPE_RUN};
    end
    return word;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 9-bit instruction word and flags
// reserved run-type opcodes.
module instr_pack
  import isa_pkg::*;
(
  input  logic       put_i,
  input  logic [4:0] opcode_i,
  input  logic [7:0] imm_i,
  output logic [8:0] instr_o,
  output logic       illegal_o
);

  // Encode fields; put-type beats are always legal.
  always_comb begin
    instr_o   = encode_instr(put_i, opcode_i, imm_i);
    illegal_o = (put_i == ITYPE_RUN) && (opcode_i > OPC_MAX);
  end

endmodule

// File: rtl/prog_encoder.sv
// Program encoder/loader: accepts instruction field beats, packs them and
// writes them sequentially into instruction ROM, stopping on an illegal
// opcode, on the last beat, or at memory capacity.
module prog_encoder
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_put,
  input  logic [4:0]        in_opcode,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_opcode,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);

  enc_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_opcode_q, err_opcode_d;
  logic              err_full_q, err_full_d;

  logic [8:0]      pack_instr;
  logic            pack_illegal;
  logic            accept;
  logic [ADDR_W:0] word_count_inc;
  logic            at_capacity;

  instr_pack u_instr_pack (
    .put_i     (in_put),
    .opcode_i  (in_opcode),
    .imm_i     (in_imm),
    .instr_o   (pack_instr),
    .illegal_o (pack_illegal)
  );

  // Handshake and capacity qualifiers; in_ready depends on state only.
  always_comb begin
    accept         = in_valid && (state_q == StLoad);
    word_count_inc = word_count_q + (ADDR_W + 1)'(1);
    // Writing this beat fills the ROM or uses the last addressable slot.
    at_capacity    = (word_count_inc == DepthW) || (addr_q == AddrMax);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start wins over any beat offered in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (start) begin
          state_d = StLoad;
        end else if (accept) begin
          if (pack_illegal) begin
            state_d = StErr;
          end else if (in_last || at_capacity) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state_q == StLoad) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Datapath next-state: address counter, write register and status flags.
  always_comb begin
    addr_d       = addr_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    err_opcode_d = err_opcode_q;
    err_full_d   = err_full_q;
    if (start) begin
      addr_d       = base_addr;
      word_count_d = '0;
      done_d       = 1'b0;
      err_opcode_d = 1'b0;
      err_full_d   = 1'b0;
    end else if (accept) begin
      if (pack_illegal) begin
        err_opcode_d = 1'b1;
      end else begin
        wr_en_d      = 1'b1;
        wr_addr_d    = addr_q;
        wr_data_d    = pack_instr;
        // A wrap here is harmless: the session ends on the same beat.
        addr_d       = addr_q + ADDR_W'(1);
        word_count_d = word_count_inc;
        if (in_last) begin
          done_d = 1'b1;
        end else if (at_capacity) begin
          done_d     = 1'b1;
          err_full_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      word_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      err_opcode_q <= 1'b0;
      err_full_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_opcode_q <= err_opcode_d;
      err_full_q   <= err_full_d;
    end
  end

  // Registered outputs.
  always_comb begin
    wr_en      = wr_en_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
    done       = done_q;
    err_opcode = err_opcode_q;
    err_full   = err_full_q;
    word_count = word_count_q;
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Bench for prog_encoder: a full-size instance and a DEPTH=4 instance share
// the same stimulus, each tracked by its own session-level reference model.
module tb_prog_encoder;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_put;
  logic [4:0]    in_opcode;
  logic [7:0]    in_imm;
  logic          in_last;

  logic          rdy, wr_en, busy, done, eop, efull;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic [AW:0]   wc;

  logic          rdy_s, wr_en_s, busy_s, done_s, eop_s, efull_s;
  logic [AW-1:0] wr_addr_s;
  logic [8:0]    wr_data_s;
  logic [AW:0]   wc_s;

  prog_encoder #(.ADDR_W(AW), .DEPTH(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(rdy), .in_put(in_put), .in_opcode(in_opcode),
    .in_imm(in_imm), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err_opcode(eop),
    .err_full(efull), .word_count(wc)
  );

  prog_encoder #(.ADDR_W(AW), .DEPTH(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(rdy_s), .in_put(in_put), .in_opcode(in_opcode),
    .in_imm(in_imm), .in_last(in_last), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
    .wr_data(wr_data_s), .busy(busy_s), .done(done_s), .err_opcode(eop_s),
    .err_full(efull_s), .word_count(wc_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Session-level model: what the loader should show after each clock edge.
  typedef struct {
    bit active;
    int addr;
    int count;
    bit done;
    bit eop;
    bit efull;
    bit wr_en;
    int wr_addr;
    int wr_data;
    int depth;
  } model_t;

  model_t mb, ms;

  function automatic model_t m_reset(int depth);
    model_t m;
    m.active = 0; m.addr = 0; m.count = 0; m.done = 0; m.eop = 0; m.efull = 0;
    m.wr_en = 0; m.wr_addr = 0; m.wr_data = 0; m.depth = depth;
    return m;
  endfunction

  function automatic model_t m_step(model_t m, bit st, int base, bit v, bit put, int opc,
                                    int imm, bit last);
    m.wr_en = 0;
    if (st) begin
      m.active = 1; m.addr = base; m.count = 0;
      m.done = 0; m.eop = 0; m.efull = 0;
    end else if (m.active && v) begin
      if (!put && opc > 17) begin
        m.eop = 1; m.active = 0;
      end else begin
        m.wr_en   = 1;
        m.wr_addr = m.addr;
        m.wr_data = put ? imm * 2 + 1 : opc * 2;
        m.count   = m.count + 1;
        if (last) begin
          m.done = 1; m.active = 0;
        end else if (m.count == m.depth || m.addr == (1 << AW) - 1) begin
          m.done = 1; m.efull = 1; m.active = 0;
        end
        m.addr = (m.addr + 1) % (1 << AW);
      end
    end
    return m;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", int'(rdy), int'(mb.active));
    chk("busy", int'(busy), int'(mb.active));
    chk("wr_en", int'(wr_en), int'(mb.wr_en));
    if (mb.wr_en) begin
      chk("wr_addr", int'(wr_addr), mb.wr_addr);
      chk("wr_data", int'(wr_data), mb.wr_data);
    end
    chk("done", int'(done), int'(mb.done));
    chk("err_opcode", int'(eop), int'(mb.eop));
    chk("err_full", int'(efull), int'(mb.efull));
    chk("word_count", int'(wc), mb.count);
    chk("s.in_ready", int'(rdy_s), int'(ms.active));
    chk("s.wr_en", int'(wr_en_s), int'(ms.wr_en));
    if (ms.wr_en) begin
      chk("s.wr_addr", int'(wr_addr_s), ms.wr_addr);
      chk("s.wr_data", int'(wr_data_s), ms.wr_data);
    end
    chk("s.done", int'(done_s), int'(ms.done));
    chk("s.err_opcode", int'(eop_s), int'(ms.eop));
    chk("s.err_full", int'(efull_s), int'(ms.efull));
    chk("s.word_count", int'(wc_s), ms.count);
  endtask

  // Advance one clock with the current inputs and compare against the models.
  task automatic step_cycle();
    mb = m_step(mb, start, int'(base_addr), in_valid, in_put, int'(in_opcode),
                int'(in_imm), in_last);
    ms = m_step(ms, start, int'(base_addr), in_valid, in_put, int'(in_opcode),
                int'(in_imm), in_last);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_start(int base);
    start = 1'b1; base_addr = AW'(base);
    step_cycle();
    start = 1'b0;
  endtask

  task automatic beat(bit put, int opc, int imm, bit last);
    in_valid = 1'b1; in_put = put; in_opcode = 5'(opc); in_imm = 8'(imm); in_last = last;
    step_cycle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  typedef struct {
    bit put;
    int opc;
    int imm;
    int exp_data;
    bit exp_illegal;
  } vec_t;

  vec_t vecs[10];
  int   nwr;

  initial begin
    vecs[0] = '{1'b1, 5'h00, 8'hA5, 9'h14B, 1'b0};
    vecs[1] = '{1'b0, 5'h03, 8'h00, 9'h006, 1'b0};
    vecs[2] = '{1'b0, 5'h10, 8'h00, 9'h020, 1'b0};
    vecs[3] = '{1'b0, 5'h11, 8'hFF, 9'h022, 1'b0};
    vecs[4] = '{1'b0, 5'h12, 8'h00, 9'h000, 1'b1};
    vecs[5] = '{1'b0, 5'h1F, 8'h00, 9'h000, 1'b1};
    vecs[6] = '{1'b1, 5'h00, 8'h00, 9'h001, 1'b0};
    vecs[7] = '{1'b1, 5'h1F, 8'hFF, 9'h1FF, 1'b0};
    vecs[8] = '{1'b0, 5'h00, 8'hFF, 9'h000, 1'b0};
    vecs[9] = '{1'b1, 5'h1F, 8'h3C, 9'h079, 1'b0};

    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_put = 1'b0; in_opcode = '0; in_imm = '0; in_last = 1'b0;
    mb = m_reset(4096);
    ms = m_reset(4);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset wr_addr", int'(wr_addr), 0);
    chk("reset wr_data", int'(wr_data), 0);
    reset = 1'b0;

    // Basic session from the example program.
    do_start(12'h010);
    beat(1'b1, 0, 8'hA5, 1'b0);
    chk("ex0 addr", int'(wr_addr), 12'h010); chk("ex0 data", int'(wr_data), 9'h14B);
    beat(1'b0, 5'h03, 0, 1'b0);
    chk("ex1 addr", int'(wr_addr), 12'h011); chk("ex1 data", int'(wr_data), 9'h006);
    beat(1'b0, 5'h10, 0, 1'b1);
    chk("ex2 addr", int'(wr_addr), 12'h012); chk("ex2 data", int'(wr_data), 9'h020);
    chk("ex done", int'(done), 1); chk("ex count", int'(wc), 3);
    step_cycle();

    // Encoding table, one single-beat session per vector.
    for (int i = 0; i < 10; i++) begin
      do_start(12'h200 + i);
      beat(vecs[i].put, vecs[i].opc, vecs[i].imm, 1'b1);
      if (vecs[i].exp_illegal) begin
        chk($sformatf("vec%0d err_opcode", i), int'(eop), 1);
        chk($sformatf("vec%0d wr_en", i), int'(wr_en), 0);
      end else begin
        chk($sformatf("vec%0d wr_data", i), int'(wr_data), vecs[i].exp_data);
        chk($sformatf("vec%0d done", i), int'(done), 1);
      end
    end

    // Illegal opcode as second beat aborts with no further writes.
    do_start(0);
    beat(1'b1, 0, 8'h11, 1'b0);
    beat(1'b0, 5'h12, 0, 1'b0);
    chk("illegal err_opcode", int'(eop), 1);
    chk("illegal in_ready", int'(rdy), 0);
    chk("illegal wr_en", int'(wr_en), 0);
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 0, i, 1'b0);
      nwr += int'(wr_en);
    end
    chk("illegal later writes", nwr, 0);

    // Capacity on the DEPTH=4 instance: six beats, no last.
    do_start(0);
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, 0, 8'h40 + i, 1'b0);
      nwr += int'(wr_en_s);
      if (i == 3) chk("full ready drop", int'(rdy_s), 0);
    end
    chk("full writes", nwr, 4);
    chk("full done", int'(done_s), 1);
    chk("full err_full", int'(efull_s), 1);

    // Top of address space: no wrap-around.
    do_start(12'hFFE);
    for (int i = 0; i < 3; i++) beat(1'b0, 5'h05, 0, 1'b0);
    chk("wrap err_full", int'(efull), 1);
    chk("wrap count", int'(wc), 2);

    // Reset with a write pending.
    do_start(12'h300);
    beat(1'b1, 0, 8'h77, 1'b0);
    chk("pre-reset wr_en", int'(wr_en), 1);
    reset = 1'b1;
    #1;
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst s.wr_en", int'(wr_en_s), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst in_ready", int'(rdy), 0);
    chk("rst count", int'(wc), 0);
    chk("rst wr_addr", int'(wr_addr), 0);
    chk("rst wr_data", int'(wr_data), 0);
    mb = m_reset(4096);
    ms = m_reset(4);
    @(negedge clk);
    reset = 1'b0;
    do_start(12'h020);
    beat(1'b0, 5'h01, 0, 1'b1);
    chk("post-reset addr", int'(wr_addr), 12'h020);

    // Restart mid-session; the beat offered with start is discarded.
    do_start(0);
    beat(1'b1, 0, 8'h01, 1'b0);
    beat(1'b1, 0, 8'h02, 1'b0);
    start = 1'b1; base_addr = 12'h100;
    beat(1'b1, 0, 8'h03, 1'b0);
    start = 1'b0;
    chk("restart pending write", int'(wr_addr), 12'h001);
    beat(1'b1, 0, 8'h04, 1'b0);
    chk("restart addr", int'(wr_addr), 12'h100);
    chk("restart count", int'(wc), 1);

    // Randomized traffic with sporadic restarts and illegal opcodes.
    for (int c = 0; c < 400; c++) begin
      start = 1'b0;
      if (!mb.active || $urandom_range(0, 49) == 0) begin
        start = 1'b1;
        base_addr = AW'($urandom);
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_put    = 1'($urandom_range(0, 1));
      in_opcode = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31))
                                               : 5'($urandom_range(0, 17));
      in_imm    = 8'($urandom);
      in_last   = ($urandom_range(0, 19) == 0);
      step_cycle();
    end
    start = 1'b0; in_valid = 1'b0;
    step_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
